// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcode groups (id_opcode[6:2], same encodings as the
// main decoder), pipe sequencer FSM states and halt causes.
package rv_pkg;

   localparam logic [4:0] OPG_R     = 5'b01100;
   localparam logic [4:0] OPG_B     = 5'b11000;
   localparam logic [4:0] OPG_S     = 5'b01000;
   localparam logic [4:0] OPG_I     = 5'b00100;
   localparam logic [4:0] OPG_L     = 5'b00000;
   localparam logic [4:0] OPG_JALR  = 5'b11001;
   localparam logic [4:0] OPG_LUI   = 5'b01101;
   localparam logic [4:0] OPG_AUIPC = 5'b00101;
   localparam logic [4:0] OPG_JAL   = 5'b11011;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } seq_state_t;

   typedef enum logic [1:0] {
      HC_NONE        = 2'b00,
      HC_ILLEGAL     = 2'b01,
      HC_MEM_TIMEOUT = 2'b10
   } halt_cause_t;

endpackage

// File: rtl/src_use_decode.sv
// Maps the ID opcode to the source registers it reads, flagging unknown opcodes.
module src_use_decode
   import rv_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       uses_rs1,
   output logic       uses_rs2,
   output logic       illegal
);

   always_comb begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      illegal  = 1'b0;
      if (opcode[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (opcode[6:2])
            OPG_R, OPG_B, OPG_S: begin
               uses_rs1 = 1'b1;
               uses_rs2 = 1'b1;
            end
            OPG_I, OPG_L, OPG_JALR: uses_rs1 = 1'b1;
            OPG_LUI, OPG_AUIPC, OPG_JAL: ;
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer for the 5-stage RV32I core: stage enables, flushes, load-use
// bubbles, data-memory freeze with timeout, and sticky halt.
module pipe_sequencer
   import rv_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       id_opcode,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memtoreg,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_bubble,
   output logic             halted,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output seq_state_t       dbg_state
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [7:0]       TMO     = 8'(MEM_TIMEOUT);

   seq_state_t  state;
   halt_cause_t cause_q;
   logic        id_valid, ex_valid;
   logic [7:0]  wait_cnt;

   logic uses_rs1, uses_rs2, illegal;
   logic mem_stall, freeze, rules_active, timeout;
   logic redirect, illegal_id, hazard;
   logic idv_n, exv_n;

   src_use_decode u_dec (
      .opcode   (id_opcode),
      .uses_rs1 (uses_rs1),
      .uses_rs2 (uses_rs2),
      .illegal  (illegal)
   );

   // Data-memory handshake: a MEM-stage access (mem_req) completes in the cycle
   // mem_ready is high; every cycle with mem_req & !mem_ready freezes the pipe.
   assign mem_stall = mem_req & ~mem_ready;

   assign redirect   = ex_valid & ex_redirect;
   assign illegal_id = id_valid & illegal;
   assign hazard     = id_valid & ex_valid & ex_memtoreg & (ex_rd != 5'd0) &
                       ((uses_rs1 & (ex_rd == id_rs1)) | (uses_rs2 & (ex_rd == id_rs2)));

   assign rules_active = ((state == RUN) & ~mem_stall) | ((state == MEM_WAIT) & mem_ready);
   assign timeout      = (state == MEM_WAIT) & ~mem_ready & (wait_cnt == TMO);

   always_comb begin
      case (state)
         RUN:      freeze = mem_stall;
         MEM_WAIT: freeze = ~mem_ready;
         HALT:     freeze = mem_stall & (cause_q != HC_MEM_TIMEOUT);
         default:  freeze = 1'b0;
      endcase
   end

   // Valid-bit update when the RUN rules apply; redirect outranks illegal and load-use.
   always_comb begin
      idv_n = 1'b1;
      exv_n = id_valid;
      if (redirect) begin
         idv_n = 1'b0;
         exv_n = 1'b0;
      end else if (illegal_id | hazard) begin
         idv_n = id_valid;
         exv_n = 1'b0;
      end
   end

   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;
      if (rst_n) begin
         if (freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
         end else if (state == HALT) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end else if (redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (illegal_id | hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         cause_q   <= HC_NONE;
         halted    <= 1'b0;
         id_valid  <= 1'b0;
         ex_valid  <= 1'b0;
         wait_cnt  <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if ((state != HALT) && !pc_en && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + 1'b1;
         if (rules_active && redirect && (flush_cnt != CNT_MAX))
            flush_cnt <= flush_cnt + 1'b1;

         case (state)
            RUN: begin
               if (mem_stall) begin
                  wait_cnt <= 8'd1;
                  state    <= MEM_WAIT;
               end
            end
            MEM_WAIT: begin
               if (!mem_ready) begin
                  if (timeout) begin
                     state    <= HALT;
                     halted   <= 1'b1;
                     cause_q  <= HC_MEM_TIMEOUT;
                     ex_valid <= 1'b0;
                  end else begin
                     wait_cnt <= wait_cnt + 8'd1;
                  end
               end else begin
                  state <= RUN;
               end
            end
            HALT: begin
               if (!freeze) ex_valid <= 1'b0;
            end
            default: state <= RUN;
         endcase

         if (rules_active) begin
            id_valid <= idv_n;
            ex_valid <= exv_n;
            if (illegal_id && !redirect) begin
               state   <= HALT;
               halted  <= 1'b1;
               cause_q <= HC_ILLEGAL;
            end
         end
      end
   end

   assign halt_cause = cause_q;
   assign dbg_state  = state;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: load-use, redirect, memory freeze/timeout,
// illegal-opcode halt and asynchronous reset.
module tb_pipe_sequencer;
   import rv_pkg::*;

   localparam logic [6:0] CTL_RUN    = 7'b1111000;
   localparam logic [6:0] CTL_FREEZE = 7'b0000001;
   localparam logic [6:0] CTL_STALL  = 7'b0011010;
   localparam logic [6:0] CTL_REDIR  = 7'b1111110;

   logic clk, rst_n;
   logic [6:0] id_opcode;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic ex_memtoreg, ex_redirect, mem_req, mem_ready;
   logic pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, halted;
   logic [1:0] halt_cause;
   logic [15:0] stall_cnt, flush_cnt;
   seq_state_t dbg_state;
   logic [6:0] ctl;

   int checks = 0;
   int failures = 0;

   pipe_sequencer #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .ex_rd(ex_rd), .ex_memtoreg(ex_memtoreg), .ex_redirect(ex_redirect),
      .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
      .idex_en(idex_en), .exmem_en(exmem_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .memwb_bubble(memwb_bubble), .halted(halted),
      .halt_cause(halt_cause), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .dbg_state(dbg_state)
   );

   assign ctl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic idle_inputs();
      id_opcode   = 7'h13;
      id_rs1      = 5'd0;
      id_rs2      = 5'd0;
      ex_rd       = 5'd0;
      ex_memtoreg = 1'b0;
      ex_redirect = 1'b0;
      mem_req     = 1'b0;
      mem_ready   = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // reset into a full pipe: id_valid = ex_valid = 1
   task automatic fill_pipe();
      do_reset();
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      mem_req = 1'b1;
      #1;
      checks++; if (ctl !== CTL_RUN) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_RUN); end
      checks++; if (halted !== 1'b0 || halt_cause !== 2'b00) begin failures++; $display("FAIL reset_halt got=%b/%b exp=0/00", halted, halt_cause); end
      checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
      checks++; if (dbg_state !== RUN) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, RUN); end
   endtask

   task automatic test_load_use();
      fill_pipe();
      id_opcode = 7'h33; id_rs1 = 5'd5; id_rs2 = 5'd1; ex_rd = 5'd5; ex_memtoreg = 1'b1;
      #1;
      checks++; if (ctl !== CTL_STALL) begin failures++; $display("FAIL lu_stall got=%b exp=%b", ctl, CTL_STALL); end
      tick();
      checks++; if (ctl !== CTL_RUN) begin failures++; $display("FAIL lu_proceed got=%b exp=%b", ctl, CTL_RUN); end
      checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
      tick();
      id_rs1 = 5'd0; ex_rd = 5'd0;
      #1;
      checks++; if (ctl !== CTL_RUN) begin failures++; $display("FAIL lu_x0 got=%b exp=%b", ctl, CTL_RUN); end
      ex_rd = 5'd1; id_rs1 = 5'd2; id_opcode = 7'h13;
      #1;
      checks++; if (ctl !== CTL_RUN) begin failures++; $display("FAIL lu_itype_rs2 got=%b exp=%b", ctl, CTL_RUN); end
      id_opcode = 7'h23;
      #1;
      checks++; if (ctl !== CTL_STALL) begin failures++; $display("FAIL lu_store_rs2 got=%b exp=%b", ctl, CTL_STALL); end
      id_opcode = 7'h37;
      #1;
      checks++; if (ctl !== CTL_RUN) begin failures++; $display("FAIL lu_lui got=%b exp=%b", ctl, CTL_RUN); end
   endtask

   task automatic test_redirect();
      do_reset();
      ex_redirect = 1'b1;
      #1;
      checks++; if (ctl !== CTL_RUN) begin failures++; $display("FAIL redir_no_exvalid got=%b exp=%b", ctl, CTL_RUN); end
      ex_redirect = 1'b0;
      tick();
      tick();
      id_opcode = 7'h33; id_rs1 = 5'd5; ex_rd = 5'd5; ex_memtoreg = 1'b1; ex_redirect = 1'b1;
      #1;
      checks++; if (ctl !== CTL_REDIR) begin failures++; $display("FAIL redir_ctl got=%b exp=%b", ctl, CTL_REDIR); end
      tick();
      ex_redirect = 1'b0;
      #1;
      checks++; if (ctl !== CTL_RUN) begin failures++; $display("FAIL redir_after got=%b exp=%b", ctl, CTL_RUN); end
      checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin failures++; $display("FAIL redir_cnt got=%0d/%0d exp=1/0", flush_cnt, stall_cnt); end
   endtask

   task automatic test_illegal_flushed();
      fill_pipe();
      id_opcode = 7'h7F; ex_redirect = 1'b1;
      #1;
      checks++; if (ctl !== CTL_REDIR) begin failures++; $display("FAIL illflush_ctl got=%b exp=%b", ctl, CTL_REDIR); end
      tick();
      ex_redirect = 1'b0;
      #1;
      checks++; if (ctl !== CTL_RUN) begin failures++; $display("FAIL illflush_next got=%b exp=%b", ctl, CTL_RUN); end
      id_opcode = 7'h13;
      tick();
      checks++; if (halted !== 1'b0 || dbg_state !== RUN) begin failures++; $display("FAIL illflush_halt got=%b/%0d exp=0/%0d", halted, dbg_state, RUN); end
   endtask

   task automatic test_illegal();
      do_reset();
      tick();
      id_opcode = 7'h31;
      #1;
      checks++; if (ctl !== CTL_STALL) begin failures++; $display("FAIL ill_lowbits got=%b exp=%b", ctl, CTL_STALL); end
      id_opcode = 7'h7F;
      #1;
      checks++; if (ctl !== CTL_STALL) begin failures++; $display("FAIL ill_ctl got=%b exp=%b", ctl, CTL_STALL); end
      tick();
      id_opcode = 7'h13;
      #1;
      checks++; if (halted !== 1'b1 || halt_cause !== 2'b01) begin failures++; $display("FAIL ill_halt got=%b/%b exp=1/01", halted, halt_cause); end
      checks++; if (ctl !== CTL_STALL || dbg_state !== HALT) begin failures++; $display("FAIL ill_drain got=%b/%0d exp=%b/%0d", ctl, dbg_state, CTL_STALL, HALT); end
      tick();
      tick();
      checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL ill_stall_cnt got=%0d exp=1", stall_cnt); end
      mem_req = 1'b1;
      #1;
      checks++; if (ctl !== CTL_FREEZE) begin failures++; $display("FAIL ill_mem_honour got=%b exp=%b", ctl, CTL_FREEZE); end
   endtask

   task automatic test_mem_wait();
      fill_pipe();
      mem_req = 1'b1;
      #1;
      checks++; if (ctl !== CTL_FREEZE) begin failures++; $display("FAIL mw_c1 got=%b exp=%b", ctl, CTL_FREEZE); end
      tick();
      checks++; if (ctl !== CTL_FREEZE || dbg_state !== MEM_WAIT) begin failures++; $display("FAIL mw_c2 got=%b/%0d exp=%b/%0d", ctl, dbg_state, CTL_FREEZE, MEM_WAIT); end
      tick();
      checks++; if (ctl !== CTL_FREEZE) begin failures++; $display("FAIL mw_c3 got=%b exp=%b", ctl, CTL_FREEZE); end
      tick();
      mem_ready = 1'b1;
      #1;
      checks++; if (ctl !== CTL_RUN) begin failures++; $display("FAIL mw_release got=%b exp=%b", ctl, CTL_RUN); end
      checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL mw_stall_cnt got=%0d exp=3", stall_cnt); end
      tick();
      mem_req = 1'b0;
      checks++; if (dbg_state !== RUN || stall_cnt !== 16'd3) begin failures++; $display("FAIL mw_back got=%0d/%0d exp=%0d/3", dbg_state, stall_cnt, RUN); end
   endtask

   task automatic test_mem_redirect();
      fill_pipe();
      mem_req = 1'b1; ex_redirect = 1'b1;
      #1;
      checks++; if (ctl !== CTL_FREEZE) begin failures++; $display("FAIL mr_freeze got=%b exp=%b", ctl, CTL_FREEZE); end
      tick();
      tick();
      mem_ready = 1'b1;
      #1;
      checks++; if (ctl !== CTL_REDIR) begin failures++; $display("FAIL mr_service got=%b exp=%b", ctl, CTL_REDIR); end
      tick();
      checks++; if (flush_cnt !== 16'd1 || dbg_state !== RUN) begin failures++; $display("FAIL mr_after got=%0d/%0d exp=1/%0d", flush_cnt, dbg_state, RUN); end
   endtask

   task automatic test_timeout();
      fill_pipe();
      mem_req = 1'b1;
      repeat (4) tick();
      checks++; if (dbg_state !== MEM_WAIT || ctl !== CTL_FREEZE) begin failures++; $display("FAIL tmo_wait got=%0d/%b exp=%0d/%b", dbg_state, ctl, MEM_WAIT, CTL_FREEZE); end
      tick();
      checks++; if (halted !== 1'b1 || halt_cause !== 2'b10) begin failures++; $display("FAIL tmo_halt got=%b/%b exp=1/10", halted, halt_cause); end
      checks++; if (ctl !== CTL_STALL) begin failures++; $display("FAIL tmo_ignore_mem got=%b exp=%b", ctl, CTL_STALL); end
      checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL tmo_stall_cnt got=%0d exp=5", stall_cnt); end
      mem_ready = 1'b1;
      repeat (3) tick();
      checks++; if (halted !== 1'b1 || dbg_state !== HALT) begin failures++; $display("FAIL tmo_sticky got=%b/%0d exp=1/%0d", halted, dbg_state, HALT); end
      rst_n = 1'b0;
      #1;
      checks++; if (halted !== 1'b0 || halt_cause !== 2'b00 || dbg_state !== RUN) begin failures++; $display("FAIL tmo_reset got=%b/%b/%0d exp=0/00/%0d", halted, halt_cause, dbg_state, RUN); end
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_wait();
      fill_pipe();
      mem_req = 1'b1;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (ctl !== CTL_RUN || dbg_state !== RUN) begin failures++; $display("FAIL rmw_ctl got=%b/%0d exp=%b/%0d", ctl, dbg_state, CTL_RUN, RUN); end
      checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin failures++; $display("FAIL rmw_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_redirect();
      test_illegal_flushed();
      test_illegal();
      test_mem_wait();
      test_mem_redirect();
      test_timeout();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Pipeline sequencer for the 5-stage RV32I core. It owns stage enables, flushes and bubble insertion, tracks ID/EX valid bits, and detects load-use hazards using the same opcode grouping as the main decoder. It freezes the pipe on a multi-cycle data-memory handshake with a timeout, and halts on an illegal opcode or a memory timeout. It sits beside the decoder in ID and drives the enables of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive wait cycles in MEM_WAIT before halting (1..255).
- CNT_W, 16: width of the performance counters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_opcode  in  7  opcode of the instruction in ID
- id_rs1, id_rs2  in  5 each  source registers of the ID instruction
- ex_rd  in  5  destination of the EX instruction
- ex_memtoreg  in  1  EX instruction is a load
- ex_redirect  in  1  EX branch taken, or JAL/JALR resolved
- mem_req  in  1  MEM instruction is a load/store
- mem_ready  in  1  data memory completes this cycle
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register enables
- ifid_flush, idex_flush  out  1 each  load a bubble
- memwb_bubble  out  1  MEM/WB captures a bubble
- halted  out  1  sticky halt
- halt_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters

## Operation
- Opcode groups use id_opcode[6:2]:
  - rs1 and rs2: R 01100, B 11000, S 01000.
  - rs1 only: I 00100, L 00000, JALR 11001.
  - No sources: LUI 01101, AUIPC 00101, JAL 11011.
  - Illegal: any other value, or id_opcode[1:0] != 11.
- Load-use hazard: id_valid & ex_valid & ex_memtoreg & ex_rd != 0 & (ex_rd == id_rs1 for groups using rs1, or ex_rd == id_rs2 for groups using rs2).
- Internal state:
  - FSM RUN / MEM_WAIT / HALT.
  - id_valid and ex_valid bits.
  - 8-bit wait counter.
- Rules in RUN, highest priority first:
  1. Memory wait (mem_req & !mem_ready):
     - pc_en = ifid_en = idex_en = exmem_en = 0; memwb_bubble = 1.
     - Wait counter set to 1; next state MEM_WAIT.
  2. Redirect (ex_valid & ex_redirect):
     - All enables 1; ifid_flush = idex_flush = 1.
     - id_valid and ex_valid cleared; flush_cnt++.
  3. Illegal opcode in ID (id_valid):
     - pc_en = ifid_en = 0; idex_flush = 1; ex_valid cleared.
     - halt_cause = 01; next state HALT.
  4. Load-use hazard:
     - pc_en = ifid_en = 0; idex_flush = 1; exmem_en = 1.
     - ex_valid cleared; id_valid held.
  5. Otherwise:
     - All enables 1; ex_valid <= id_valid; id_valid <= 1.
- MEM_WAIT:
  - While !mem_ready: same outputs as rule 1; wait counter increments.
  - Timeout: when the counter reaches MEM_TIMEOUT and mem_ready is still 0:
    - halt_cause = 10; next state HALT.
    - The MEM instruction is dropped: memwb_bubble = 1.
  - On mem_ready: rules 2–5 are evaluated that same cycle; next state RUN.
- HALT:
  - pc_en = ifid_en = 0; idex_flush = 1; exmem_en = 1; halted = 1.
  - The pipe drains. The memory handshake is still honoured (freeze while mem_req & !mem_ready) unless halt_cause = 10; in that case mem_req is ignored.
  - HALT is left only by reset.
- Counters:
  - stall_cnt increments in every cycle with pc_en = 0 outside HALT.
  - Both counters saturate at all-ones.

## Timing
- All enable, flush and bubble outputs are combinational from state and inputs; no added latency.
- Registered state updates on the rising clk edge.
- Reset (async assert, sync-safe deassert):
  - State RUN; id_valid = ex_valid = 0.
  - Counters = 0; halted = 0; halt_cause = 00.
  - Reset output values: all enables = 1, flushes = 0, memwb_bubble = 0.
- Load-use costs exactly one bubble: the stalled instruction proceeds in the next cycle because ex_valid is now 0.
- Redirect costs 2 bubbles.
- A redirect coinciding with a load-use hazard or an illegal opcode: redirect wins; no halt and no stall.
- A redirect pending during MEM_WAIT is serviced in the mem_ready cycle.
- Reset during MEM_WAIT or HALT: returns to RUN immediately.

## Structure
- The shared package `rv_pkg` holds:
  - the opcode-group localparams (same encodings the decoder uses);
  - the `seq_state_t` enum {RUN, MEM_WAIT, HALT};
  - the `halt_cause_t` 2-bit enum.
- One natural sub-module: `src_use_decode`. It is combinational, mapping id_opcode to {uses_rs1, uses_rs2, illegal}.

## Test plan
- Load-use: lw x5 in EX, add x6,x5,x1 in ID.
  - Required: one cycle with pc_en = 0 and idex_flush = 1; stall_cnt = 1.
  - Repeat with ex_rd = 0: no stall.
- Redirect: ex_redirect = 1 with ex_valid.
  - Required: ifid_flush = idex_flush = 1 for one cycle; flush_cnt = 1.
  - A load-use hazard in the same cycle is ignored.
- Memory wait: mem_req = 1 with mem_ready low for 3 cycles.
  - Required: 3 freeze cycles with memwb_bubble = 1; stall_cnt = 3.
  - Release on the 4th cycle; state back to RUN.
- Timeout (MEM_TIMEOUT = 4): mem_ready held low.
  - Required: HALT after 4 wait cycles; halt_cause = 10; halted = 1 until reset.
- Illegal opcode 0x7F reaches ID.
  - Required: HALT next cycle with halt_cause = 01; EX/MEM continues to drain.
  - An illegal opcode that is flushed by a redirect does not halt.
- Assert rst_n in MEM_WAIT mid-wait.
  - Required: all outputs at reset values asynchronously; counters = 0.
